run_ctrl: RTL and testbench

Run-sequencing controller for the basic processor's program counter. It replaces a bare count-enable bit with a full start/load/run/halt sequencer. The block takes the testbench Start handshake and selects one of four program entry points. It loads the PC, gates PC counting around datapath stalls, detects the Halt instruction, and reports Done along with a run-length cycle count. It sits between the testbench/top level and the PC, instruction decoder and data memory stall logic.

---
 rtl/run_ctrl.sv | 128 ++++++++++++
 tb/tb_run_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run sequencer for the PC: start/load/run/halt with a run-length counter.
// Optional watchdog: define RUN_WATCHDOG_EN.
module run_ctrl #(
  parameter int          PC_W         = 10,
  parameter int          CNT_W        = 16,
  parameter logic [PC_W-1:0] START_ADDR_0 = '0,
  parameter logic [PC_W-1:0] START_ADDR_1 = '0,
  parameter logic [PC_W-1:0] START_ADDR_2 = '0,
  parameter logic [PC_W-1:0] START_ADDR_3 = '0,
  parameter int          WDOG_LIMIT   = 4095
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  input  logic             StallReq,
  output logic             CountEn,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcStartAddr,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [2:0] {
    IDLE, ARMED, LOAD, RUN, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] sel;
  logic       latch;
  logic       wdog_to;
  logic       wdog_hit;

`ifdef RUN_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);
  logic timeout_q;

  assign wdog_hit = (CycleCount == WDOG_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      timeout_q <= 1'b0;
    else if (state == LOAD)
      timeout_q <= 1'b0;
    else if (wdog_to)
      timeout_q <= 1'b1;
  end

  assign Timeout = timeout_q;
`else
  assign wdog_hit = 1'b0;
  assign Timeout  = 1'b0;
`endif

  // Abort beats halt, halt beats watchdog.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    wdog_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = ARMED;
          latch     = 1'b1;
        end
      end
      ARMED: begin
        if (!Start)
          state_nxt = LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (Start) begin
          state_nxt = ARMED;
          latch     = 1'b1;
        end else if (Halt) begin
          state_nxt = DONE;
        end else if (wdog_hit) begin
          state_nxt = DONE;
          wdog_to   = 1'b1;
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt = ARMED;
          latch     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      sel        <= 2'd0;
      CycleCount <= '0;
    end else begin
      state <= state_nxt;
      if (latch)
        sel <= ProgSel;
      if (state == LOAD)
        CycleCount <= '0;
      else if (state == RUN && CycleCount != '1)
        CycleCount <= CycleCount + 1'b1;
    end
  end

  always_comb begin
    PcStartAddr = START_ADDR_0;
    unique case (sel)
      2'd0: PcStartAddr = START_ADDR_0;
      2'd1: PcStartAddr = START_ADDR_1;
      2'd2: PcStartAddr = START_ADDR_2;
      2'd3: PcStartAddr = START_ADDR_3;
      default: PcStartAddr = START_ADDR_0;
    endcase
  end

  assign CountEn = (state == RUN) && !StallReq && !Halt;
  assign PcLoad  = (state == LOAD);
  assign Busy    = (state == ARMED) || (state == LOAD) || (state == RUN);
  assign Done    = (state == DONE);

endmodule

// File: tb/tb_run_ctrl.sv
// Directed vector bench for run_ctrl: table-driven run sequences
// plus hand-written reset and watchdog corner cases.
module tb_run_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic        StallReq;
  logic        CountEn;
  logic        PcLoad;
  logic [9:0]  PcStartAddr;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;

`ifdef RUN_WATCHDOG_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif

  always #5 Clk = ~Clk;

  run_ctrl #(
    .PC_W(10), .CNT_W(16),
    .START_ADDR_0(10'h000), .START_ADDR_1(10'h123),
    .START_ADDR_2(10'h040), .START_ADDR_3(10'h3F0),
    .WDOG_LIMIT(20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .ProgSel(ProgSel), .Halt(Halt), .StallReq(StallReq),
    .CountEn(CountEn), .PcLoad(PcLoad),
    .PcStartAddr(PcStartAddr), .Busy(Busy), .Done(Done),
    .Timeout(Timeout), .CycleCount(CycleCount)
  );

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic        halt;
    logic        stall;
    logic        ce;
    logic        pl;
    logic [9:0]  addr;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    logic s, logic [1:0] p, logic h, logic st,
    logic ce, logic pl, logic [9:0] a,
    logic b, logic d, logic [15:0] c);
    vec_t r;
    r.start = s; r.sel = p; r.halt = h; r.stall = st;
    r.ce = ce; r.pl = pl; r.addr = a;
    r.busy = b; r.done = d; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] p,
                       input logic h, input logic st);
    @(negedge Clk);
    Start = s; ProgSel = p; Halt = h; StallReq = st;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".CountEn"}, 32'(CountEn), 0);
    chk({tag, ".PcLoad"}, 32'(PcLoad), 0);
    chk({tag, ".PcStartAddr"}, 32'(PcStartAddr), 0);
    chk({tag, ".Busy"}, 32'(Busy), 0);
    chk({tag, ".Done"}, 32'(Done), 0);
    chk({tag, ".Timeout"}, 32'(Timeout), 0);
    chk({tag, ".CycleCount"}, 32'(CycleCount), 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0;
    Halt = 1'b0; StallReq = 1'b0;
    #2;
    chk_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Basic run, prog 2: halt on 6th RUN cycle
    tbl.push_back(v(1,2,0,0, 0,0,10'h000,0,0,0));
    tbl.push_back(v(1,2,0,0, 0,0,10'h040,1,0,0));
    tbl.push_back(v(1,2,0,0, 0,0,10'h040,1,0,0));
    tbl.push_back(v(0,2,0,0, 0,0,10'h040,1,0,0));
    tbl.push_back(v(0,0,0,0, 0,1,10'h040,1,0,0));
    tbl.push_back(v(0,0,0,0, 1,0,10'h040,1,0,0));
    tbl.push_back(v(0,0,0,0, 1,0,10'h040,1,0,1));
    tbl.push_back(v(0,0,0,0, 1,0,10'h040,1,0,2));
    tbl.push_back(v(0,0,0,0, 1,0,10'h040,1,0,3));
    tbl.push_back(v(0,0,0,0, 1,0,10'h040,1,0,4));
    tbl.push_back(v(0,0,1,0, 0,0,10'h040,1,0,5));
    tbl.push_back(v(0,0,0,0, 0,0,10'h040,0,1,6));
    tbl.push_back(v(0,0,0,0, 0,0,10'h040,0,1,6));
    // Restart prog 1, stall on RUN 2-4, halt on 8
    tbl.push_back(v(1,1,0,0, 0,0,10'h040,0,1,6));
    tbl.push_back(v(0,0,0,0, 0,0,10'h123,1,0,6));
    tbl.push_back(v(0,0,0,0, 0,1,10'h123,1,0,6));
    tbl.push_back(v(0,0,0,0, 1,0,10'h123,1,0,0));
    tbl.push_back(v(0,0,0,1, 0,0,10'h123,1,0,1));
    tbl.push_back(v(0,0,0,1, 0,0,10'h123,1,0,2));
    tbl.push_back(v(0,0,0,1, 0,0,10'h123,1,0,3));
    tbl.push_back(v(0,0,0,0, 1,0,10'h123,1,0,4));
    tbl.push_back(v(0,0,0,0, 1,0,10'h123,1,0,5));
    tbl.push_back(v(0,0,0,0, 1,0,10'h123,1,0,6));
    tbl.push_back(v(0,0,1,0, 0,0,10'h123,1,0,7));
    tbl.push_back(v(0,0,0,0, 0,0,10'h123,0,1,8));
    // Prog 3: halt+stall in first RUN cycle
    tbl.push_back(v(1,3,0,0, 0,0,10'h123,0,1,8));
    tbl.push_back(v(0,0,0,0, 0,0,10'h3F0,1,0,8));
    tbl.push_back(v(0,0,0,0, 0,1,10'h3F0,1,0,8));
    tbl.push_back(v(0,0,1,1, 0,0,10'h3F0,1,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,10'h3F0,0,1,1));
    // Prog 2, then Start+Halt together restarts into prog 1
    tbl.push_back(v(1,2,0,0, 0,0,10'h3F0,0,1,1));
    tbl.push_back(v(0,0,0,0, 0,0,10'h040,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,1,10'h040,1,0,1));
    tbl.push_back(v(0,0,0,0, 1,0,10'h040,1,0,0));
    tbl.push_back(v(1,1,1,0, 0,0,10'h040,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,10'h123,1,0,2));
    tbl.push_back(v(0,0,0,0, 0,1,10'h123,1,0,2));
    tbl.push_back(v(0,0,0,0, 1,0,10'h123,1,0,0));
    tbl.push_back(v(0,0,1,0, 0,0,10'h123,1,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,10'h123,0,1,2));

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(tbl[i].start, tbl[i].sel, tbl[i].halt, tbl[i].stall);
      chk({t, ".CountEn"}, 32'(CountEn), 32'(tbl[i].ce));
      chk({t, ".PcLoad"}, 32'(PcLoad), 32'(tbl[i].pl));
      chk({t, ".PcStartAddr"}, 32'(PcStartAddr), 32'(tbl[i].addr));
      chk({t, ".Busy"}, 32'(Busy), 32'(tbl[i].busy));
      chk({t, ".Done"}, 32'(Done), 32'(tbl[i].done));
      chk({t, ".CycleCount"}, 32'(CycleCount), 32'(tbl[i].cnt));
      chk({t, ".Timeout"}, 32'(Timeout), 0);
    end

    // Long run without halt: watchdog fires after 20 RUN cycles if built in
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("wd.load", 32'(PcLoad), 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0);
      chk($sformatf("wd.run%0d.ce", i), 32'(CountEn), 1);
      chk($sformatf("wd.run%0d.cnt", i), 32'(CycleCount), 32'(i));
    end
    drive(0, 0, 0, 0);
    chk("wd.end.cnt", 32'(CycleCount), 20);
    chk("wd.end.done", 32'(Done), 32'(WD));
    chk("wd.end.busy", 32'(Busy), 32'(!WD));
    chk("wd.end.timeout", 32'(Timeout), 32'(WD));
    chk("wd.end.ce", 32'(CountEn), 32'(!WD));
    drive(1, 1, 0, 0);
    chk("wd.sticky0", 32'(Timeout), 32'(WD));
    drive(0, 1, 0, 0);
    chk("wd.sticky1", 32'(Timeout), 32'(WD));
    chk("wd.rearm.addr", 32'(PcStartAddr), 32'h123);
    drive(0, 1, 0, 0);
    chk("wd.sticky2", 32'(Timeout), 32'(WD));
    chk("wd.reload", 32'(PcLoad), 1);
    drive(0, 0, 1, 0);
    chk("wd.cleared", 32'(Timeout), 0);
    chk("wd.halt.ce", 32'(CountEn), 0);
    drive(0, 0, 0, 0);
    chk("wd.halt.done", 32'(Done), 1);
    chk("wd.halt.cnt", 32'(CycleCount), 1);

    // Asynchronous reset in the middle of a run
    drive(1, 2, 0, 0);
    drive(0, 2, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("mid.cnt", 32'(CycleCount), 1);
    chk("mid.busy", 32'(Busy), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    Start = 1'b1;
    ProgSel = 2'd3;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.hold.busy", 32'(Busy), 0);
    chk("rst.hold.addr", 32'(PcStartAddr), 0);
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;
    drive(0, 0, 0, 0);
    chk_all_zero("postreset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
